// File: rtl/uart_pkg.sv
// Shared UART types: parity mode encodings, parity engine state enum and helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE00 = 2'b00,
        PAR_ODD    = 2'b01,
        PAR_EVEN   = 2'b10,
        PAR_NONE11 = 2'b11
    } par_type_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_WAIT_PAR = 2'd2
    } par_state_t;

    function automatic logic par_is_none(input par_type_t t);
        return (t == PAR_NONE00) || (t == PAR_NONE11);
    endfunction

    // x is the XOR of all data bits; "none" frames drive a constant 1 (idle line level)
    function automatic logic par_gen(input par_type_t t, input logic x);
        case (t)
            PAR_ODD:  return ~x;
            PAR_EVEN: return x;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/parity_serial_engine_if.sv
// Bit-stream / result bus between a UART shifter (master) and the parity engine (slave).
// Error counter signals exist only when PARITY_ERR_CNT_EN is defined.
interface parity_serial_engine_if
`ifdef PARITY_ERR_CNT_EN
    #(parameter int CNT_WIDTH = 8)
`endif
    ;
    logic [1:0] parity_type;
    logic       start;
    logic       bit_valid;
    logic       bit_in;
    logic       par_valid;
    logic       par_in;
    logic       parity_bit;
    logic       gen_done;
    logic       chk_done;
    logic       par_err;
    logic       busy;
`ifdef PARITY_ERR_CNT_EN
    logic                 err_clr;
    logic [CNT_WIDTH-1:0] err_count;
`endif

    modport master (
        output parity_type, start, bit_valid, bit_in, par_valid, par_in,
`ifdef PARITY_ERR_CNT_EN
        output err_clr,
        input  err_count,
`endif
        input  parity_bit, gen_done, chk_done, par_err, busy
    );

    modport slave (
        input  parity_type, start, bit_valid, bit_in, par_valid, par_in,
`ifdef PARITY_ERR_CNT_EN
        input  err_clr,
        output err_count,
`endif
        output parity_bit, gen_done, chk_done, par_err, busy
    );

endinterface

// File: rtl/parity_err_cnt.sv
// Saturating parity error counter; a clear coincident with an error leaves the count at one.
module parity_err_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/parity_serial_engine.sv
// Serial parity generator/checker, one per UART direction.
// Optional saturating error counter enabled by defining PARITY_ERR_CNT_EN.
//
// state       | meaning
// ST_IDLE     | no frame in progress, parity_bit holds last result
// ST_ACCUM    | folding data bits into acc until DATA_WIDTH bits seen
// ST_WAIT_PAR | parity generated, waiting for received parity bit
module parity_serial_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
`ifdef PARITY_ERR_CNT_EN
    ,
    parameter int CNT_WIDTH  = 8
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    parity_serial_engine_if.slave  bus
);

    localparam int             CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(DATA_WIDTH - 1);

    par_state_t    state_q, state_nxt;
    par_type_t     mode_q, mode_nxt;
    logic          acc_q, acc_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          parity_q, parity_nxt;
    logic          gen_done_q, gen_done_nxt;
    logic          chk_done_q, chk_done_nxt;
    logic          par_err_q, par_err_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= PAR_NONE00;
            acc_q      <= 1'b0;
            cnt_q      <= '0;
            parity_q   <= 1'b1;
            gen_done_q <= 1'b0;
            chk_done_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            mode_q     <= mode_nxt;
            acc_q      <= acc_nxt;
            cnt_q      <= cnt_nxt;
            parity_q   <= parity_nxt;
            gen_done_q <= gen_done_nxt;
            chk_done_q <= chk_done_nxt;
            par_err_q  <= par_err_nxt;
        end
    end

    // start outranks everything, including a data or parity bit in the same cycle
    always_comb begin
        state_nxt    = state_q;
        mode_nxt     = mode_q;
        acc_nxt      = acc_q;
        cnt_nxt      = cnt_q;
        parity_nxt   = parity_q;
        gen_done_nxt = 1'b0;
        chk_done_nxt = 1'b0;
        par_err_nxt  = 1'b0;
        if (bus.start) begin
            state_nxt = ST_ACCUM;
            mode_nxt  = par_type_t'(bus.parity_type);
            acc_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.bit_valid) begin
                        acc_nxt = acc_q ^ bus.bit_in;
                        cnt_nxt = cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) begin
                            parity_nxt   = par_gen(mode_q, acc_nxt);
                            gen_done_nxt = 1'b1;
                            state_nxt    = par_is_none(mode_q) ? ST_IDLE : ST_WAIT_PAR;
                        end
                    end
                end
                ST_WAIT_PAR: begin
                    if (bus.par_valid) begin
                        chk_done_nxt = 1'b1;
                        par_err_nxt  = (bus.par_in != parity_q);
                        state_nxt    = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.parity_bit = parity_q;
    assign bus.gen_done   = gen_done_q;
    assign bus.chk_done   = chk_done_q;
    assign bus.par_err    = par_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_count;

    parity_err_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (par_err_q),
        .clr     (bus.err_clr),
        .count   (err_count)
    );

    assign bus.err_count = err_count;
`endif

endmodule

// File: tb/tb_parity_serial_engine.sv
// Directed bench for parity_serial_engine: 8-bit and 7-bit instances; counter checks
// run only when PARITY_ERR_CNT_EN is defined.
module tb_parity_serial_engine;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   ntests = 0;
    int   nfail = 0;
    int   gd_seen = 0;

    always #5 clk = ~clk;

`ifdef PARITY_ERR_CNT_EN
    parity_serial_engine_if #(.CNT_WIDTH(2)) if8 ();
    parity_serial_engine_if #(.CNT_WIDTH(2)) if7 ();
    parity_serial_engine #(.DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
    parity_serial_engine #(.DATA_WIDTH(7), .CNT_WIDTH(2)) u_dut7 (.clk(clk), .reset_n(reset_n), .bus(if7.slave));
`else
    parity_serial_engine_if if8 ();
    parity_serial_engine_if if7 ();
    parity_serial_engine #(.DATA_WIDTH(8)) u_dut8 (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
    parity_serial_engine #(.DATA_WIDTH(7)) u_dut7 (.clk(clk), .reset_n(reset_n), .bus(if7.slave));
`endif

    typedef struct {
        logic [1:0] ptype;
        logic [7:0] data;
        logic       par_in;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        gd_seen += int'(if8.gen_done);
    endtask

    task automatic send_bits8(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            if8.bit_valid = 1'b1;
            if8.bit_in    = data[i];
            tick();
        end
        if8.bit_valid = 1'b0;
        if8.bit_in    = 1'b0;
    endtask

    task automatic start8(input logic [1:0] ptype);
        if8.parity_type = ptype;
        if8.start       = 1'b1;
        tick();
        if8.start       = 1'b0;
    endtask

    // complete frame on the 8-bit instance; clr_at_err raises err_clr while par_err is high
    task automatic frame8(input string tag, input logic [1:0] ptype, input logic [7:0] data,
                          input logic par_in, input logic exp_par, input logic exp_err,
                          input logic clr_at_err);
        start8(ptype);
        check({tag, " busy"}, int'(if8.busy), 1);
        send_bits8(data, 7);
        check({tag, " early gen_done"}, int'(if8.gen_done), 0);
        send_bits8(data >> 7, 1);
        check({tag, " gen_done"}, int'(if8.gen_done), 1);
        check({tag, " parity_bit"}, int'(if8.parity_bit), int'(exp_par));
        if (par_is_none(par_type_t'(ptype))) begin
            check({tag, " none idle"}, int'(if8.busy), 0);
            if8.par_valid = 1'b1;
            if8.par_in    = par_in;
            tick();
            if8.par_valid = 1'b0;
            check({tag, " none chk_done"}, int'(if8.chk_done), 0);
            check({tag, " none par_err"}, int'(if8.par_err), 0);
        end else begin
            check({tag, " wait busy"}, int'(if8.busy), 1);
            if8.par_valid = 1'b1;
            if8.par_in    = par_in;
            tick();
            if8.par_valid = 1'b0;
            check({tag, " chk_done"}, int'(if8.chk_done), 1);
            check({tag, " par_err"}, int'(if8.par_err), int'(exp_err));
            check({tag, " parity held"}, int'(if8.parity_bit), int'(exp_par));
`ifdef PARITY_ERR_CNT_EN
            if8.err_clr = clr_at_err;
`else
            if (clr_at_err) check({tag, " clr unsupported"}, 1, 0);
`endif
            tick();
`ifdef PARITY_ERR_CNT_EN
            if8.err_clr = 1'b0;
`endif
            check({tag, " chk pulse end"}, int'(if8.chk_done), 0);
            check({tag, " back idle"}, int'(if8.busy), 0);
        end
    endtask

    initial begin
        {if8.parity_type, if8.start, if8.bit_valid, if8.bit_in, if8.par_valid, if8.par_in} = '0;
        {if7.parity_type, if7.start, if7.bit_valid, if7.bit_in, if7.par_valid, if7.par_in} = '0;
`ifdef PARITY_ERR_CNT_EN
        if8.err_clr = 1'b0;
        if7.err_clr = 1'b0;
`endif
        vecs[0] = '{PAR_EVEN,   8'h53, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{PAR_ODD,    8'h53, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{PAR_NONE00, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{PAR_EVEN,   8'h01, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{PAR_ODD,    8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{PAR_EVEN,   8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{PAR_NONE11, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{PAR_ODD,    8'h7F, 1'b0, 1'b0, 1'b0};

        tick();
        tick();
        check("rst parity_bit", int'(if8.parity_bit), 1);
        check("rst busy", int'(if8.busy), 0);
        check("rst gen_done", int'(if8.gen_done), 0);
        check("rst chk_done", int'(if8.chk_done), 0);
        check("rst par_err", int'(if8.par_err), 0);
`ifdef PARITY_ERR_CNT_EN
        check("rst err_count", int'(if8.err_count), 0);
`endif
        reset_n = 1'b1;
        tick();

        // bit_valid in IDLE must not start a frame
        if8.bit_valid = 1'b1;
        tick();
        if8.bit_valid = 1'b0;
        check("idle ignores bits", int'(if8.busy), 0);

        for (int v = 0; v < 8; v++) begin
            frame8($sformatf("vec%0d", v), vecs[v].ptype, vecs[v].data, vecs[v].par_in,
                   vecs[v].exp_par, vecs[v].exp_err, 1'b0);
        end
`ifdef PARITY_ERR_CNT_EN
        check("err_count after table", int'(if8.err_count), 2);
`endif

        // 7-bit instance, even, 0x7F with 3-cycle gaps between bits
        if7.parity_type = PAR_EVEN;
        if7.start = 1'b1;
        tick();
        if7.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if7.bit_valid = 1'b1;
            if7.bit_in    = 1'b1;
            tick();
            if7.bit_valid = 1'b0;
            if (i < 6) begin
                check($sformatf("w7 gen_done bit%0d", i), int'(if7.gen_done), 0);
                tick(); tick(); tick();
                check($sformatf("w7 busy gap%0d", i), int'(if7.busy), 1);
            end
        end
        check("w7 gen_done", int'(if7.gen_done), 1);
        check("w7 parity_bit", int'(if7.parity_bit), 1);
        if7.par_valid = 1'b1;
        if7.par_in    = 1'b1;
        tick();
        if7.par_valid = 1'b0;
        check("w7 chk_done", int'(if7.chk_done), 1);
        check("w7 par_err", int'(if7.par_err), 0);
        tick();

        // abort after 4 bits; restart with a bit_valid that must be discarded
        gd_seen = 0;
        start8(PAR_EVEN);
        send_bits8(8'hFF, 4);
        if8.start     = 1'b1;
        if8.bit_valid = 1'b1;
        if8.bit_in    = 1'b1;
        tick();
        if8.start     = 1'b0;
        if8.bit_valid = 1'b0;
        check("abort busy", int'(if8.busy), 1);
        send_bits8(8'h01, 7);
        check("abort no early gen", int'(if8.gen_done), 0);
        send_bits8(8'h00, 1);
        check("abort parity_bit", int'(if8.parity_bit), 1);
        check("abort gen pulses", gd_seen, 1);

        // start with par_valid in WAIT_PAR: start wins, no check
        if8.parity_type = PAR_EVEN;
        if8.start       = 1'b1;
        if8.par_valid   = 1'b1;
        if8.par_in      = 1'b0;
        tick();
        if8.start       = 1'b0;
        if8.par_valid   = 1'b0;
        check("wp abort chk_done", int'(if8.chk_done), 0);
        check("wp abort par_err", int'(if8.par_err), 0);
        check("wp abort busy", int'(if8.busy), 1);
        send_bits8(8'h53, 8);
        check("wp frame parity", int'(if8.parity_bit), 0);
        if8.par_valid = 1'b1;
        if8.par_in    = 1'b0;
        tick();
        if8.par_valid = 1'b0;
        check("wp chk_done", int'(if8.chk_done), 1);

        // back-to-back: start in the chk_done cycle
        if8.parity_type = PAR_ODD;
        if8.start       = 1'b1;
        tick();
        if8.start       = 1'b0;
        check("b2b busy", int'(if8.busy), 1);
        check("b2b chk_done low", int'(if8.chk_done), 0);
        send_bits8(8'h53, 8);
        check("b2b gen_done", int'(if8.gen_done), 1);
        check("b2b parity", int'(if8.parity_bit), 1);
        if8.par_valid = 1'b1;
        if8.par_in    = 1'b1;
        tick();
        if8.par_valid = 1'b0;
        check("b2b par_err", int'(if8.par_err), 0);
        tick();

`ifdef PARITY_ERR_CNT_EN
        frame8("sat0", PAR_ODD, 8'h53, 1'b0, 1'b1, 1'b1, 1'b0);
        frame8("sat1", PAR_ODD, 8'h53, 1'b0, 1'b1, 1'b1, 1'b0);
        check("err_count saturated", int'(if8.err_count), 3);
        frame8("clr", PAR_ODD, 8'h53, 1'b0, 1'b1, 1'b1, 1'b1);
        check("err_count clr+err", int'(if8.err_count), 1);
        if8.err_clr = 1'b1;
        tick();
        if8.err_clr = 1'b0;
        check("err_count clr", int'(if8.err_count), 0);
        frame8("cnt1", PAR_EVEN, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        check("err_count inc", int'(if8.err_count), 1);
`endif

        // reset lands on the cycle of the last data bit
        frame8("pre_rst", PAR_EVEN, 8'h53, 1'b0, 1'b0, 1'b0, 1'b0);
        start8(PAR_EVEN);
        send_bits8(8'hFF, 7);
        if8.bit_valid = 1'b1;
        if8.bit_in    = 1'b1;
        reset_n       = 1'b0;
        tick();
        if8.bit_valid = 1'b0;
        check("mid rst gen_done", int'(if8.gen_done), 0);
        check("mid rst busy", int'(if8.busy), 0);
        check("mid rst parity_bit", int'(if8.parity_bit), 1);
        check("mid rst chk_done", int'(if8.chk_done), 0);
        check("mid rst par_err", int'(if8.par_err), 0);
`ifdef PARITY_ERR_CNT_EN
        check("mid rst err_count", int'(if8.err_count), 0);
`endif
        reset_n = 1'b1;
        tick();
        frame8("post_rst", PAR_ODD, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
